// File: rtl/prio_deco_seq_pkg.sv
// Shared definitions for the code-to-one-hot pulse sequencer: code width, line count,
// FSM state encodings and the 3-to-8 decode helper.
package prio_deco_seq_pkg;

  localparam int CODE_W = 3;
  localparam int LINES  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Decoding is total: every code selects exactly one line, code 0 -> bit 0.
  function automatic logic [LINES-1:0] decode_code(input logic [CODE_W-1:0] code);
    logic [LINES-1:0] lines;
    lines       = '0;
    lines[code] = 1'b1;
    return lines;
  endfunction

endpackage

// File: rtl/prio_deco_seq_code_fifo.sv
// Small first-word-fall-through FIFO of encoder codes; the head entry is visible on rdata
// while not empty, and pointers wrap naturally because DEPTH is a power of two.
import prio_deco_seq_pkg::*;

module prio_deco_seq_code_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [CODE_W-1:0]           wdata,
  input  logic                        pop,
  output logic [CODE_W-1:0]           rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [CODE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // A simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prio_deco_seq.sv
// Replays buffered 3-bit codes as registered one-hot pulses of HOLD_CYCLES cycles, each
// followed by GAP_CYCLES forced-low cycles; enable only gates starting a new pulse.
import prio_deco_seq_pkg::*;

module prio_deco_seq #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              e,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic [LINES-1:0]  out_onehot,
  output logic              out_active,
  output logic              busy,
  output logic              ovf
);

  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CODE_W-1:0]    head_code;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                 push;
  logic                 pop;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && e && !fifo_empty;
  assign busy     = (state != IDLE) || (fifo_count != '0);

  prio_deco_seq_code_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_code),
    .pop   (pop),
    .rdata (head_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // One counter serves both the HOLD and GAP windows; it counts down to zero in each.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      out_onehot <= '0;
      out_active <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        ovf <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            out_onehot <= decode_code(head_code);
            out_active <= 1'b1;
            cnt        <= CNT_W'(HOLD_CYCLES - 1);
            state      <= HOLD;
          end else begin
            out_onehot <= '0;
            out_active <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            out_onehot <= '0;
            out_active <= 1'b0;
            if (GAP_CYCLES > 0) begin
              cnt   <= CNT_W'(GAP_CYCLES - 1);
              state <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_deco_seq.sv
// Directed bench for prio_deco_seq: a default instance (GAP_CYCLES=1) plus a GAP_CYCLES=0
// instance, with hand-computed one-hot pulse timelines sampled on the falling edge.
module tb_prio_deco_seq;

  logic       clk;
  logic       rst;
  logic       e;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic [7:0] out_onehot;
  logic       out_active;
  logic       busy;
  logic       ovf;

  logic       g0_e;
  logic       g0_in_valid;
  logic [2:0] g0_in_code;
  logic       g0_in_ready;
  logic [7:0] g0_out_onehot;
  logic       g0_out_active;
  logic       g0_busy;
  logic       g0_ovf;

  int checks;
  int failures;

  prio_deco_seq #(.DEPTH(4), .HOLD_CYCLES(2), .GAP_CYCLES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .e          (e),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_ready   (in_ready),
    .out_onehot (out_onehot),
    .out_active (out_active),
    .busy       (busy),
    .ovf        (ovf)
  );

  prio_deco_seq #(.DEPTH(4), .HOLD_CYCLES(2), .GAP_CYCLES(0)) dut_g0 (
    .clk        (clk),
    .rst        (rst),
    .e          (g0_e),
    .in_valid   (g0_in_valid),
    .in_code    (g0_in_code),
    .in_ready   (g0_in_ready),
    .out_onehot (g0_out_onehot),
    .out_active (g0_out_active),
    .busy       (g0_busy),
    .ovf        (g0_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] code, input logic en);
    in_valid = v;
    in_code  = code;
    e        = en;
  endtask

  task automatic applyStimulusG0(input logic v, input logic [2:0] code, input logic en);
    g0_in_valid = v;
    g0_in_code  = code;
    g0_e        = en;
  endtask

  // Advance one cycle and compare the default instance's pulse outputs.
  task automatic stepCheck(input string tag, input logic [7:0] exp);
    @(negedge clk);
    checkOutput(tag, out_onehot, exp);
    checkOutput({tag, "_act"}, {7'b0, out_active}, {7'b0, (exp != 8'h00)});
  endtask

  task automatic stepCheckG0(input string tag, input logic [7:0] exp);
    @(negedge clk);
    checkOutput(tag, g0_out_onehot, exp);
    checkOutput({tag, "_act"}, {7'b0, g0_out_active}, {7'b0, (exp != 8'h00)});
  endtask

  // Two low cycles then two high cycles per code, matching HOLD=2 and GAP=1.
  task automatic pulseTrain(input string tag, input logic [7:0] exp);
    stepCheck({tag, "_lo0"}, 8'h00);
    stepCheck({tag, "_lo1"}, 8'h00);
    stepCheck({tag, "_hi0"}, exp);
    stepCheck({tag, "_hi1"}, exp);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    applyStimulus(1'b0, 3'd0, 1'b0);
    applyStimulusG0(1'b0, 3'd0, 1'b0);
    doReset();
    checkOutput("rst_onehot", out_onehot, 8'h00);
    checkOutput("rst_busy", {7'b0, busy}, 8'h00);
    checkOutput("rst_ready", {7'b0, in_ready}, 8'h01);
    checkOutput("rst_ovf", {7'b0, ovf}, 8'h00);

    // Reset asserted mid-HOLD of code 5 cuts the pulse off.
    applyStimulus(1'b1, 3'd5, 1'b1);
    stepCheck("r5_push", 8'h00);
    applyStimulus(1'b0, 3'd0, 1'b1);
    stepCheck("r5_hi", 8'h20);
    rst = 1'b1;
    stepCheck("r5_cut", 8'h00);
    checkOutput("r5_busy", {7'b0, busy}, 8'h00);
    checkOutput("r5_ready", {7'b0, in_ready}, 8'h01);
    checkOutput("r5_ovf", {7'b0, ovf}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Single code 3: high for exactly two cycles starting one cycle after the push edge.
    applyStimulus(1'b1, 3'd3, 1'b1);
    stepCheck("s3_push", 8'h00);
    checkOutput("s3_busy", {7'b0, busy}, 8'h01);
    applyStimulus(1'b0, 3'd0, 1'b1);
    stepCheck("s3_hi0", 8'h08);
    stepCheck("s3_hi1", 8'h08);
    stepCheck("s3_off", 8'h00);
    stepCheck("s3_gap", 8'h00);
    checkOutput("s3_idle_busy", {7'b0, busy}, 8'h00);

    // Burst 7,0,4 on consecutive cycles.
    applyStimulus(1'b1, 3'd7, 1'b1);
    stepCheck("b_push7", 8'h00);
    applyStimulus(1'b1, 3'd0, 1'b1);
    stepCheck("b7_hi0", 8'h80);
    applyStimulus(1'b1, 3'd4, 1'b1);
    stepCheck("b7_hi1", 8'h80);
    applyStimulus(1'b0, 3'd0, 1'b1);
    pulseTrain("b0", 8'h01);
    pulseTrain("b4", 8'h10);
    stepCheck("b_end0", 8'h00);
    stepCheck("b_end1", 8'h00);
    checkOutput("b_busy", {7'b0, busy}, 8'h00);

    // Fill with e low, overflow on the fifth push, then drain exactly four pulses.
    applyStimulus(1'b1, 3'd1, 1'b0);
    stepCheck("f_p1", 8'h00);
    checkOutput("f_ready1", {7'b0, in_ready}, 8'h01);
    applyStimulus(1'b1, 3'd2, 1'b0);
    stepCheck("f_p2", 8'h00);
    applyStimulus(1'b1, 3'd3, 1'b0);
    stepCheck("f_p3", 8'h00);
    checkOutput("f_ready3", {7'b0, in_ready}, 8'h01);
    applyStimulus(1'b1, 3'd4, 1'b0);
    stepCheck("f_p4", 8'h00);
    checkOutput("f_ready4", {7'b0, in_ready}, 8'h00);
    checkOutput("f_ovf_pre", {7'b0, ovf}, 8'h00);
    applyStimulus(1'b1, 3'd6, 1'b0);
    stepCheck("f_p5", 8'h00);
    checkOutput("f_ovf", {7'b0, ovf}, 8'h01);
    applyStimulus(1'b0, 3'd0, 1'b1);
    stepCheck("f1_hi0", 8'h02);
    checkOutput("f_ready_pop", {7'b0, in_ready}, 8'h01);
    stepCheck("f1_hi1", 8'h02);
    pulseTrain("f2", 8'h04);
    pulseTrain("f3", 8'h08);
    pulseTrain("f4", 8'h10);
    stepCheck("f_end0", 8'h00);
    stepCheck("f_end1", 8'h00);
    stepCheck("f_end2", 8'h00);
    checkOutput("f_nofifth", {7'b0, busy}, 8'h00);
    checkOutput("f_ovf_sticky", {7'b0, ovf}, 8'h01);
    doReset();
    checkOutput("f_ovf_clr", {7'b0, ovf}, 8'h00);

    // Enable drops during HOLD of code 2; code 6 waits until e returns.
    applyStimulus(1'b1, 3'd2, 1'b1);
    stepCheck("e_push2", 8'h00);
    applyStimulus(1'b1, 3'd6, 1'b1);
    stepCheck("e2_hi0", 8'h04);
    applyStimulus(1'b0, 3'd0, 1'b0);
    stepCheck("e2_hi1", 8'h04);
    stepCheck("e2_off", 8'h00);
    stepCheck("e_wait0", 8'h00);
    stepCheck("e_wait1", 8'h00);
    stepCheck("e_wait2", 8'h00);
    checkOutput("e_busy", {7'b0, busy}, 8'h01);
    applyStimulus(1'b0, 3'd0, 1'b1);
    stepCheck("e6_hi0", 8'h40);
    stepCheck("e6_hi1", 8'h40);
    stepCheck("e6_off", 8'h00);
    stepCheck("e6_gap", 8'h00);

    // Push while popping at count=3: occupancy stays 3, so one more push fills it exactly.
    applyStimulus(1'b1, 3'd1, 1'b0);
    stepCheck("pp_p1", 8'h00);
    applyStimulus(1'b1, 3'd2, 1'b0);
    stepCheck("pp_p2", 8'h00);
    applyStimulus(1'b1, 3'd3, 1'b0);
    stepCheck("pp_p3", 8'h00);
    applyStimulus(1'b1, 3'd5, 1'b1);
    stepCheck("pp1_hi0", 8'h02);
    checkOutput("pp_ready", {7'b0, in_ready}, 8'h01);
    applyStimulus(1'b1, 3'd7, 1'b1);
    stepCheck("pp1_hi1", 8'h02);
    checkOutput("pp_full", {7'b0, in_ready}, 8'h00);
    checkOutput("pp_ovf", {7'b0, ovf}, 8'h00);
    applyStimulus(1'b0, 3'd0, 1'b1);
    pulseTrain("pp2", 8'h04);
    pulseTrain("pp3", 8'h08);
    pulseTrain("pp5", 8'h20);
    pulseTrain("pp7", 8'h80);
    stepCheck("pp_end", 8'h00);

    // Same push-while-pop on the GAP_CYCLES=0 instance: one low cycle between pulses.
    applyStimulusG0(1'b1, 3'd1, 1'b0);
    stepCheckG0("g_p1", 8'h00);
    applyStimulusG0(1'b1, 3'd2, 1'b0);
    stepCheckG0("g_p2", 8'h00);
    applyStimulusG0(1'b1, 3'd3, 1'b0);
    stepCheckG0("g_p3", 8'h00);
    applyStimulusG0(1'b1, 3'd4, 1'b1);
    stepCheckG0("g1_hi0", 8'h02);
    checkOutput("g_ready", {7'b0, g0_in_ready}, 8'h01);
    applyStimulusG0(1'b0, 3'd0, 1'b1);
    stepCheckG0("g1_hi1", 8'h02);
    stepCheckG0("g2_lo", 8'h00);
    stepCheckG0("g2_hi0", 8'h04);
    stepCheckG0("g2_hi1", 8'h04);
    stepCheckG0("g3_lo", 8'h00);
    stepCheckG0("g3_hi0", 8'h08);
    stepCheckG0("g3_hi1", 8'h08);
    stepCheckG0("g4_lo", 8'h00);
    stepCheckG0("g4_hi0", 8'h10);
    stepCheckG0("g4_hi1", 8'h10);
    stepCheckG0("g_end", 8'h00);
    checkOutput("g_busy", {7'b0, g0_busy}, 8'h00);
    checkOutput("g_ovf", {7'b0, g0_ovf}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
